user_sobel_row_engine: RTL and testbench
========================================

// Module: user_sobel_row_engine
// PURPOSE
//  OBI-mapped Sobel accelerator in the user domain. Computes |Gx|+|Gy| for COUNT consecutive
//  centre pixels along one image row, fetching pixels from the user ROM over a req/valid port.
//  Uses a sliding 3x3 window, so 9 fetches for the first pixel and 3 for each following pixel.
//  Results go into a FIFO that the CPU pops; optional level interrupt on completion.
// PARAMETERS
//  IMG_W      16     image width in pixels (>=2); row-major ROM layout, addr = y*IMG_W + x
//  IMG_H      16     image height in pixels (>=2)
//  PIX_W      8      pixel/result width; pixel = rom_data_i[PIX_W-1:0]
//  ADDR_W     16     ROM address width
//  FIFO_DEPTH 4      result FIFO entries (power of 2, >=2)
//  obi_req_t  logic  OBI request struct type
//  obi_rsp_t  logic  OBI response struct type
// PORTS
//  clk_i        in   1       clock
//  rst_ni       in   1       asynchronous active-low reset
//  obi_req_i    in   struct  OBI slave request from CPU
//  obi_rsp_o    out  struct  OBI slave response
//  rom_req_o    out  1       ROM fetch request, held until rom_valid_i
//  rom_addr_o   out  ADDR_W  ROM pixel address
//  rom_data_i   in   32      ROM read data, sampled when rom_valid_i=1
//  rom_valid_i  in   1       ROM data valid, completes the current fetch
//  irq_o        out  1       level interrupt = done & irq_en
// BEHAVIOUR
//  Reset: state IDLE, all registers 0, FIFO empty, rom_req_o=0, rom_addr_o=0, irq_o=0, gnt/rvalid=0.
//  OBI: gnt = req. rvalid and rdata are registered one cycle after the grant. Reads of unmapped
//   offsets return 0. Writes to unmapped offsets are ignored.
//  Register map (word offsets):
//   0x00 CTRL   W: [0] start, [1] clr_done, [2] irq_en (sticky). R: {29'b0, irq_en, 2'b0}
//   0x04 X0     first centre x
//   0x08 Y0     centre row
//   0x0C COUNT  pixels to process (0 gives done immediately with no fetch)
//   0x10 STATUS R: [0] busy, [1] done, [2] fifo_empty, [3] fifo_full, [7:4] fifo level
//   0x14 RESULT R: pops the FIFO head, zero-extended. Read while empty returns 0 with no side effect.
//  Writes to X0, Y0, COUNT or start are ignored while busy. start clears done.
//  Effective count = min(COUNT, IMG_W - X0); X0 >= IMG_W gives done immediately.
//  FSM states: IDLE, FETCH, COMPUTE, PUSH, DONE.
//   IDLE -> FETCH on start.
//   FETCH fetches columns x-1, x, x+1 on the first pixel, then only column x+1 on later pixels.
//    Within a column the order is rows y-1, y, y+1. One request is outstanding at a time, and
//    rom_addr_o is stable while rom_req_o is high. The window shifts left one column per new pixel.
//   COMPUTE takes 1 cycle and registers the result. PUSH waits while the FIFO is full (rom_req_o=0),
//    then pushes. More pixels remain -> FETCH; otherwise -> DONE.
//   DONE sets done=1 for one cycle, then returns to IDLE. done stays set until start or clr_done.
//  Borders: clamp coordinates to [0,IMG_W-1] x [0,IMG_H-1] (edge replication).
//  Arithmetic: gx, gy are signed PIX_W+3 bits; mag = |gx|+|gy| in PIX_W+4 bits.
//   Result saturates to 2^PIX_W-1.
//  FIFO: a pop and a push in the same cycle both take effect and the level is unchanged.
//   A pop from a full FIFO frees PUSH on the next cycle.
//  Reset mid-operation returns the block to the reset state and discards the FIFO.
//  Latency: first result at 9 fetches + 2 cycles; each later result at 3 fetches + 2 cycles (no stall).
// CONFIGURATION
//  USER_SOBEL_THRESH_EN defined: adds register 0x18 THRESH [PIX_W-1:0] (reset 0, RW, ignored while
//   busy). Pushed value is 2^PIX_W-1 if saturated mag > THRESH, else 0 (binary edge map).
//  Not defined: 0x18 is unmapped, and the raw saturated magnitude is pushed.
// TESTING
//  Flat image (all 0x40), X0=5, Y0=5, COUNT=3 -> 9+3+3 fetches, FIFO holds 0,0,0, done=1.
//  Vertical step (x<8: 0, x>=8: 0xFF), X0=7, Y0=4, COUNT=2 -> results 0xFF, 0xFF (gx=1020, saturated).
//  X0=0, Y0=0, COUNT=1 -> first fetch addr 0 (clamped), 9 fetches, all addrs in {0,1,16,17}.
//  COUNT=8, FIFO_DEPTH=4, no RESULT reads -> fifo_full, rom_req_o=0, busy=1;
//   4 pops -> resumes, 8 results in order.
//  Pulse rst_ni low during FETCH -> rom_req_o=0, STATUS reads 0x4, new start runs correctly.
//  THRESH_EN, THRESH=0x80, edge mag 0xC0 and flat 0x00 -> results 0xFF and 0x00; irq_o=1 with irq_en.

Source files
------------

// File: rtl/user_sobel_row_engine.sv
// OBI-mapped Sobel row engine: fetches a sliding 3x3 window from ROM, pushes |Gx|+|Gy| into a result FIFO.
// Optional binary edge-map threshold register enabled by defining USER_SOBEL_THRESH_EN.

package user_sobel_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_rsp_t;
endpackage

// OBI handshake: gnt mirrors req in the same cycle; rvalid/rdata follow one cycle after each grant.
// ROM handshake: rom_req_o is held with a stable rom_addr_o until the cycle rom_valid_i is seen high.
module user_sobel_row_engine #(
    parameter int unsigned IMG_W      = 16,
    parameter int unsigned IMG_H      = 16,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter type         obi_req_t  = user_sobel_pkg::obi_req_t,
    parameter type         obi_rsp_t  = user_sobel_pkg::obi_rsp_t
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  obi_req_t          obi_req_i,
    output obi_rsp_t          obi_rsp_o,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]       rom_data_i,
    input  logic              rom_valid_i,
    output logic              irq_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int XMAX = int'(IMG_W) - 1;
    localparam int YMAX = int'(IMG_H) - 1;
    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_COMPUTE,
        S_PUSH,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic             irq_en_q, done_q;
    logic [15:0]      x0_q, y0_q, count_q;
    logic [15:0]      cur_x_q, remain_q;
    logic             first_q;
    logic [1:0]       fcol_q, frow_q;
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] result_q;

    logic [PIX_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [LVL_W-1:0] level_q;
    logic             fifo_full, fifo_empty;

    logic             rvalid_q;
    logic [31:0]      rdata_q, rdata_d;

`ifdef USER_SOBEL_THRESH_EN
    logic [PIX_W-1:0] thresh_q;
`endif

    // Register access decode
    logic [5:0] word;
    logic       rd_en, wr_en, wr_ctrl, start, pop, push, busy;
    logic [31:0] wdata;

    assign word    = obi_req_i.addr[7:2];
    assign wdata   = obi_req_i.wdata;
    assign rd_en   = obi_req_i.req & ~obi_req_i.we;
    assign wr_en   = obi_req_i.req & obi_req_i.we;
    assign wr_ctrl = wr_en && (word == 6'd0);
    assign busy    = (state_q != S_IDLE);
    assign start   = wr_ctrl & wdata[0] & ~busy;
    assign pop     = rd_en && (word == 6'd5) && !fifo_empty;
    assign push    = (state_q == S_PUSH) && !fifo_full;

    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);

    logic unused_bits;
    assign unused_bits = ^{obi_req_i.be, obi_req_i.addr[31:8], obi_req_i.addr[1:0],
                           wdata[31:16], rom_data_i[31:PIX_W]};

    // Pixels actually processed: COUNT clipped at the right image edge
    logic [15:0] span, eff_cnt;
    always_comb begin
        span    = '0;
        eff_cnt = '0;
        if ({16'b0, x0_q} < IMG_W) begin
            span    = 16'(IMG_W - {16'b0, x0_q});
            eff_cnt = (count_q < span) ? count_q : span;
        end
    end

    // Fetch coordinate: first pixel walks columns x-1..x+1, later pixels only x+1; clamped to the image
    int fx, fy;
    always_comb begin
        fx = int'(cur_x_q) + (first_q ? int'(fcol_q) - 1 : 1);
        fy = int'(y0_q) + int'(frow_q) - 1;
        if (fx < 0) fx = 0;
        else if (fx > XMAX) fx = XMAX;
        if (fy < 0) fy = 0;
        else if (fy > YMAX) fy = YMAX;
    end

    assign rom_req_o  = (state_q == S_FETCH);
    assign rom_addr_o = (state_q == S_FETCH) ? ADDR_W'(fy * int'(IMG_W) + fx) : '0;
    assign irq_o      = done_q & irq_en_q;

    // Sobel kernel on win_q[col][row]; columns 0/2 are x-1/x+1, rows 0/2 are y-1/y+1
    function automatic logic signed [PIX_W+2:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    logic signed [PIX_W+2:0] gx, gy;
    logic [PIX_W+2:0]        ax, ay;
    logic [PIX_W+3:0]        mag;
    logic [PIX_W-1:0]        sat, push_val;
    always_comb begin
        gx = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
        gy = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
        ax  = gx[PIX_W+2] ? $unsigned(-gx) : $unsigned(gx);
        ay  = gy[PIX_W+2] ? $unsigned(-gy) : $unsigned(gy);
        mag = {1'b0, ax} + {1'b0, ay};
        sat = (mag > {4'b0000, PIX_MAX}) ? PIX_MAX : mag[PIX_W-1:0];
`ifdef USER_SOBEL_THRESH_EN
        push_val = (sat > thresh_q) ? PIX_MAX : '0;
`else
        push_val = sat;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = (eff_cnt == '0) ? S_DONE : S_FETCH;
            S_FETCH:   if (rom_valid_i && fcol_q == 2'd2 && frow_q == 2'd2) state_d = S_COMPUTE;
            S_COMPUTE: state_d = S_PUSH;
            S_PUSH:    if (!fifo_full) state_d = (remain_q == 16'd1) ? S_DONE : S_FETCH;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Software-visible registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            x0_q     <= '0;
            y0_q     <= '0;
            count_q  <= '0;
`ifdef USER_SOBEL_THRESH_EN
            thresh_q <= '0;
`endif
        end else begin
            if (wr_ctrl) irq_en_q <= wdata[2];
            if (state_q == S_DONE) done_q <= 1'b1;
            else if (start || (wr_ctrl && wdata[1])) done_q <= 1'b0;
            if (wr_en && !busy) begin
                if (word == 6'd1) x0_q    <= wdata[15:0];
                if (word == 6'd2) y0_q    <= wdata[15:0];
                if (word == 6'd3) count_q <= wdata[15:0];
`ifdef USER_SOBEL_THRESH_EN
                if (word == 6'd6) thresh_q <= wdata[PIX_W-1:0];
`endif
            end
        end
    end

    // Window, fetch counters and pixel progress
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_x_q  <= '0;
            remain_q <= '0;
            first_q  <= 1'b0;
            fcol_q   <= '0;
            frow_q   <= '0;
            result_q <= '0;
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 3; r++) win_q[c][r] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cur_x_q  <= x0_q;
                        remain_q <= eff_cnt;
                        first_q  <= 1'b1;
                        fcol_q   <= '0;
                        frow_q   <= '0;
                    end
                end
                S_FETCH: begin
                    if (rom_valid_i) begin
                        win_q[fcol_q][frow_q] <= rom_data_i[PIX_W-1:0];
                        if (frow_q == 2'd2) begin
                            frow_q <= '0;
                            if (fcol_q != 2'd2) fcol_q <= fcol_q + 2'd1;
                        end else begin
                            frow_q <= frow_q + 2'd1;
                        end
                    end
                end
                S_COMPUTE: result_q <= push_val;
                S_PUSH: begin
                    if (!fifo_full) begin
                        remain_q <= remain_q - 16'd1;
                        cur_x_q  <= cur_x_q + 16'd1;
                        first_q  <= 1'b0;
                        fcol_q   <= 2'd2;
                        frow_q   <= '0;
                        // Slide the window one column left; column 2 is refilled next
                        for (int r = 0; r < 3; r++) begin
                            win_q[0][r] <= win_q[1][r];
                            win_q[1][r] <= win_q[2][r];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Result FIFO; simultaneous push and pop leave the level unchanged
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wptr_q] <= result_q;
                wptr_q           <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
        end
    end

    logic [7:0] status;
    assign status = {4'(level_q), fifo_full, fifo_empty, done_q, busy};

    always_comb begin
        rdata_d = '0;
        case (word)
            6'd0: rdata_d = {29'b0, irq_en_q, 2'b00};
            6'd1: rdata_d = {16'b0, x0_q};
            6'd2: rdata_d = {16'b0, y0_q};
            6'd3: rdata_d = {16'b0, count_q};
            6'd4: rdata_d = {24'b0, status};
            6'd5: if (!fifo_empty) rdata_d = 32'(fifo_mem[rptr_q]);
`ifdef USER_SOBEL_THRESH_EN
            6'd6: rdata_d = 32'(thresh_q);
`endif
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= obi_req_i.req;
            rdata_q  <= rd_en ? rdata_d : '0;
        end
    end

    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = obi_req_i.req;
        obi_rsp_o.rvalid = rvalid_q;
        obi_rsp_o.rdata  = rdata_q;
    end

endmodule

// File: tb/tb_user_sobel_row_engine.sv
// Scoreboard bench for user_sobel_row_engine: random images, reference Sobel model, fetch-address and OBI read queues.
// Exercises the USER_SOBEL_THRESH_EN register when that macro is defined.
module tb_user_sobel_row_engine;
    localparam int IMG_W      = 16;
    localparam int IMG_H      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam logic [7:0] OFF_CTRL = 8'h00, OFF_X0 = 8'h04, OFF_Y0 = 8'h08, OFF_COUNT = 8'h0C,
                           OFF_STATUS = 8'h10, OFF_RESULT = 8'h14, OFF_THRESH = 8'h18;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    user_sobel_pkg::obi_req_t obi_req;
    user_sobel_pkg::obi_rsp_t obi_rsp;
    logic                     rom_req_o;
    logic [15:0]              rom_addr_o;
    logic [31:0]              rom_data_i;
    logic                     rom_valid_i;
    logic                     irq_o;

    user_sobel_row_engine #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(8), .ADDR_W(16), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .obi_req_i  (obi_req),
        .obi_rsp_o  (obi_rsp),
        .rom_req_o  (rom_req_o),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_data_i),
        .rom_valid_i(rom_valid_i),
        .irq_o      (irq_o)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    bit          kind_q[$];
    string       name_q[$];
    logic [15:0] addr_q[$];
    int          img[IMG_W*IMG_H];
    bit          irq_en_m = 0;
    int          thresh_m = 0;
    logic [31:0] last_rdata = '0;
    int          fetch_n = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Reference model
    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int pix(input int x, input int y);
        return img[clampi(y, IMG_H-1)*IMG_W + clampi(x, IMG_W-1)];
    endfunction

    function automatic int sobel(input int x, input int y);
        int gx, gy, w, mag;
        gx = 0;
        gy = 0;
        for (int d = -1; d <= 1; d++) begin
            w  = (d == 0) ? 2 : 1;
            gx = gx + w * (pix(x+1, y+d) - pix(x-1, y+d));
            gy = gy + w * (pix(x+d, y+1) - pix(x+d, y-1));
        end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 255) mag = 255;
`ifdef USER_SOBEL_THRESH_EN
        mag = (mag > thresh_m) ? 255 : 0;
`endif
        return mag;
    endfunction

    // ROM responder: random latency, checks each presented address against the model's order
    initial begin
        int dly;
        logic [15:0] a;
        dly = 0;
        rom_valid_i = 1'b0;
        rom_data_i  = '0;
        forever begin
            @(posedge clk_i);
            #1;
            rom_valid_i = 1'b0;
            if (rst_ni && rom_req_o) begin
                if (dly == 0) begin
                    a = rom_addr_o;
                    fetch_n++;
                    if (addr_q.size() == 0) begin
                        check("fetch_extra", 32'(a), 32'hFFFF_FFFF);
                    end else begin
                        check("fetch_addr", 32'(a), 32'(addr_q.pop_front()));
                    end
                    rom_data_i  = {24'($urandom), 8'(img[int'(a) % (IMG_W*IMG_H)])};
                    rom_valid_i = 1'b1;
                    dly = $urandom_range(0, 2);
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: every rvalid retires one issued OBI transaction
    always @(negedge clk_i) begin
        if (obi_rsp.rvalid) begin
            last_rdata = obi_rsp.rdata;
            if (kind_q.size() == 0) begin
                check("rvalid_unexpected", 32'd1, 32'd0);
            end else if (kind_q.pop_front()) begin
                check(name_q.pop_front(), obi_rsp.rdata, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic obi_xfer(input bit we, input logic [7:0] off, input logic [31:0] wd,
                            input bit chk, input logic [31:0] exp, input string nm);
        @(posedge clk_i);
        #1;
        obi_req.req   = 1'b1;
        obi_req.we    = we;
        obi_req.be    = 4'hF;
        obi_req.addr  = {24'b0, off};
        obi_req.wdata = wd;
        kind_q.push_back(chk && !we);
        if (chk && !we) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
        @(negedge clk_i);
        check("gnt", 32'(obi_rsp.gnt), 32'd1);
        @(posedge clk_i);
        #1;
        obi_req = '0;
    endtask

    task automatic obi_wr(input logic [7:0] off, input logic [31:0] wd);
        obi_xfer(1'b1, off, wd, 1'b0, '0, "");
    endtask

    task automatic obi_rd(input logic [7:0] off, input logic [31:0] exp, input string nm);
        obi_xfer(1'b0, off, '0, 1'b1, exp, nm);
    endtask

    task automatic obi_rd_raw(input logic [7:0] off, output logic [31:0] data);
        obi_xfer(1'b0, off, '0, 1'b0, '0, "");
        @(negedge clk_i);
        #1;
        data = last_rdata;
    endtask

    task automatic wait_done();
        logic [31:0] s;
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            obi_rd_raw(OFF_STATUS, s);
            if (s[1]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("done_timeout", 32'd0, 32'd1);
    endtask

    function automatic int eff_count(input int x0, input int cnt);
        if (x0 >= IMG_W) return 0;
        return (cnt < IMG_W - x0) ? cnt : IMG_W - x0;
    endfunction

    // Queue the expected fetch addresses and results for a run
    task automatic model_run(input int x0, input int y0, input int cnt, output int res[$]);
        int eff;
        res.delete();
        eff = eff_count(x0, cnt);
        for (int i = 0; i < eff; i++) begin
            for (int dx = (i == 0) ? -1 : 1; dx <= 1; dx++)
                for (int dy = -1; dy <= 1; dy++)
                    addr_q.push_back(16'(clampi(y0+dy, IMG_H-1)*IMG_W + clampi(x0+i+dx, IMG_W-1)));
            res.push_back(sobel(x0+i, y0));
        end
    endtask

    task automatic start_run(input int x0, input int y0, input int cnt);
        obi_wr(OFF_X0, 32'(x0));
        obi_wr(OFF_Y0, 32'(y0));
        obi_wr(OFF_COUNT, 32'(cnt));
        obi_wr(OFF_CTRL, {29'b0, irq_en_m, 2'b01});
    endtask

    // Full run whose results all fit in the FIFO (cnt <= FIFO_DEPTH)
    task automatic run_case(input int x0, input int y0, input int cnt);
        int res[$];
        int eff;
        model_run(x0, y0, cnt, res);
        eff = res.size();
        start_run(x0, y0, cnt);
        wait_done();
        obi_rd(OFF_STATUS, 32'(2 | (eff == 0 ? 4 : 0) | (eff == FIFO_DEPTH ? 8 : 0) | (eff << 4)),
               "status_done");
        check("irq", 32'(irq_o), 32'(irq_en_m));
        foreach (res[i]) obi_rd(OFF_RESULT, 32'(res[i]), "result");
        obi_rd(OFF_RESULT, 32'd0, "result_empty");
        check("fetch_count", 32'(addr_q.size()), 32'd0);
    endtask

    task automatic fill_random();
        foreach (img[i]) img[i] = $urandom_range(0, 255);
    endtask

    initial begin
        int res[$];
        bit seen;
        rst_ni  = 1'b0;
        obi_req = '0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Reset state
        @(negedge clk_i);
        check("rst_rom_req", 32'(rom_req_o), 32'd0);
        check("rst_rom_addr", 32'(rom_addr_o), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        obi_rd(OFF_STATUS, 32'h4, "rst_status");
        obi_rd(OFF_CTRL, 32'h0, "rst_ctrl");
        obi_rd(OFF_X0, 32'h0, "rst_x0");
        obi_rd(OFF_RESULT, 32'h0, "rst_result");
        obi_rd(8'h1C, 32'h0, "unmapped");
`ifndef USER_SOBEL_THRESH_EN
        obi_wr(OFF_THRESH, 32'h55);
        obi_rd(OFF_THRESH, 32'h0, "thresh_unmapped");
`endif

        // Flat image and vertical step
        foreach (img[i]) img[i] = 'h40;
        run_case(5, 5, 3);
        foreach (img[i]) img[i] = ((i % IMG_W) < 8) ? 0 : 'hFF;
        run_case(7, 4, 2);

        // Corner clamp, zero count, X0 out of range, right-edge truncation
        fill_random();
        run_case(0, 0, 1);
        run_case(3, 3, 0);
        run_case(16, 2, 3);
        run_case(14, 9, 4);

        // Interrupt enable, bottom clamp, clr_done
        irq_en_m = 1;
        obi_wr(OFF_CTRL, 32'h4);
        obi_rd(OFF_CTRL, 32'h4, "ctrl_irq_en");
        run_case(2, 15, 2);
        obi_wr(OFF_CTRL, 32'h6);
        @(negedge clk_i);
        check("irq_cleared", 32'(irq_o), 32'd0);
        obi_rd(OFF_STATUS, 32'h4, "status_clr_done");

        // Random runs
        for (int r = 0; r < 8; r++) begin
            fill_random();
            run_case($urandom_range(0, IMG_W-1), $urandom_range(0, IMG_H-1), $urandom_range(1, FIFO_DEPTH));
        end

        // Back-pressure: 8 pixels into a 4-deep FIFO, busy writes ignored
        fill_random();
        model_run(4, 7, 8, res);
        start_run(4, 7, 8);
        obi_wr(OFF_X0, 32'd0);
        repeat (300) @(posedge clk_i);
        @(negedge clk_i);
        check("stall_rom_req", 32'(rom_req_o), 32'd0);
        obi_rd(OFF_STATUS, 32'h49, "status_stall");
        for (int i = 0; i < 4; i++) obi_rd(OFF_RESULT, 32'(res[i]), "result_stall");
        wait_done();
        obi_rd(OFF_STATUS, 32'h4A, "status_stall_done");
        for (int i = 4; i < 8; i++) obi_rd(OFF_RESULT, 32'(res[i]), "result_stall");
        obi_rd(OFF_RESULT, 32'd0, "result_empty");
        check("fetch_count", 32'(addr_q.size()), 32'd0);
        obi_rd(OFF_X0, 32'd4, "x0_busy_write");

        // Reset in the middle of fetching the second pixel (one result already queued)
        fill_random();
        model_run(3, 3, 3, res);
        fetch_n = 0;
        start_run(3, 3, 3);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i);
            if (fetch_n >= 11) begin
                seen = 1;
                break;
            end
        end
        check("reset_fetch_reached", 32'(seen), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_rom_req", 32'(rom_req_o), 32'd0);
        check("mid_rst_rom_addr", 32'(rom_addr_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        addr_q.delete();
        irq_en_m = 0;
        thresh_m = 0;
        obi_rd(OFF_STATUS, 32'h4, "status_after_rst");
        obi_rd(OFF_CTRL, 32'h0, "ctrl_after_rst");
        run_case(6, 6, 3);

`ifdef USER_SOBEL_THRESH_EN
        // Binary edge map: edge magnitude 0xC0 above threshold, flat area below
        foreach (img[i]) img[i] = ((i % IMG_W) < 8) ? 0 : 'h30;
        thresh_m = 'h80;
        obi_wr(OFF_THRESH, 32'h80);
        obi_rd(OFF_THRESH, 32'h80, "thresh_rw");
        irq_en_m = 1;
        obi_wr(OFF_CTRL, 32'h4);
        run_case(7, 4, 4);
`endif

        repeat (3) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
